// File: rtl/uart_pkg.sv
// Shared definitions for the configurable UART receiver: parity encodings,
// FSM state type, per-frame error flags and the baud divisor helper.
package uart_pkg;

  localparam int unsigned PAR_NONE = 0;
  localparam int unsigned PAR_ODD  = 1;
  localparam int unsigned PAR_EVEN = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } rx_state_e;

  typedef struct packed {
    logic frame_err;
    logic parity_err;
  } rx_flags_t;

  function automatic int unsigned baud_div(input int unsigned clk_freq,
                                           input int unsigned baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_rx_cfg_if.sv
// Receiver-side bundle: serial line in, payload/flags out with valid/ready.
interface uart_rx_cfg_if #(
  parameter int unsigned DATA_BITS = 8
) ();

  logic                 rx_data;
  logic [DATA_BITS-1:0] po_data;
  logic                 po_valid;
  logic                 po_ready;
  logic                 frame_err;
  logic                 parity_err;
  logic                 overrun_err;
  logic                 busy;

  // master: the receiver producing payloads
  modport master (
    input  rx_data, po_ready,
    output po_data, po_valid, frame_err, parity_err, overrun_err, busy
  );

  // slave: line driver and payload consumer
  modport slave (
    output rx_data, po_ready,
    input  po_data, po_valid, frame_err, parity_err, overrun_err, busy
  );

endinterface

// File: rtl/uart_rx_sampler.sv
// Line front end: 3-flop synchroniser, falling-edge detect, baud counter and
// 2-of-3 majority vote around the bit centre.
module uart_rx_sampler
  import uart_pkg::*;
#(
  parameter int unsigned BAUD_DIV = 434
) (
  input  logic clk,
  input  logic rst_n,
  input  logic rx_data,
  input  logic idle,
  output logic fall_edge,
  output logic sample_strobe,
  output logic sample_bit,
  output logic bit_end
);

  localparam int unsigned CNT_W = $clog2(BAUD_DIV);
  localparam int unsigned MID   = (BAUD_DIV - 1) / 2;

  logic             ff1, ff2, ff3;
  logic [CNT_W-1:0] cnt;
  logic             s_lo, s_mid;

  // synchroniser resets to the idle (high) line level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ff1 <= 1'b1;
      ff2 <= 1'b1;
      ff3 <= 1'b1;
    end else begin
      ff1 <= rx_data;
      ff2 <= ff1;
      ff3 <= ff2;
    end
  end

  // held at zero while idle so the first counted cycle follows start detect
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (idle) begin
      cnt <= '0;
    end else if (cnt == CNT_W'(BAUD_DIV - 1)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_lo  <= 1'b1;
      s_mid <= 1'b1;
    end else begin
      if (cnt == CNT_W'(MID - 1)) s_lo  <= ff2;
      if (cnt == CNT_W'(MID))     s_mid <= ff2;
    end
  end

  assign fall_edge     = ff3 & ~ff2;
  assign sample_strobe = ~idle & (cnt == CNT_W'(MID + 1));
  assign sample_bit    = (s_lo & s_mid) | (s_lo & ff2) | (s_mid & ff2);
  assign bit_end       = ~idle & (cnt == CNT_W'(BAUD_DIV - 1));

endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: frame FSM, payload shift register and a
// one-entry valid/ready holding register with error and overrun reporting.
module uart_rx_cfg
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ  = 50_000_000,
  parameter int unsigned BAUD      = 115200,
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned PARITY    = 0,
  parameter int unsigned STOP_BITS = 1
) (
  input logic            clk,
  input logic            rst_n,
  uart_rx_cfg_if.master  bus
);

  localparam int unsigned BAUD_DIV = baud_div(CLK_FREQ, BAUD);
  localparam int unsigned BIT_W    = 4;

  if (BAUD_DIV < 8) begin : g_bad_baud
    $error("uart_rx_cfg: BAUD_DIV must be at least 8");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_width
    $error("uart_rx_cfg: DATA_BITS must be 5..9");
  end
  if (PARITY > PAR_EVEN) begin : g_bad_parity
    $error("uart_rx_cfg: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
    $error("uart_rx_cfg: STOP_BITS must be 1 or 2");
  end

  rx_state_e            state, state_d;
  logic [BIT_W-1:0]     bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  rx_flags_t            flags;

  logic idle;
  logic fall_edge, sample_strobe, sample_bit, bit_end;
  logic start_c, shift_c, bit_clr_c, bit_inc_c, par_chk_c, stop_chk_c, complete_c;
  logic par_exp;

  logic [DATA_BITS-1:0] po_data_q;
  logic                 po_valid_q;
  rx_flags_t            po_flags_q;
  logic                 overrun_q;
  logic                 busy_q;

  assign idle = (state == ST_IDLE);

  uart_rx_sampler #(
    .BAUD_DIV (BAUD_DIV)
  ) u_sampler (
    .clk           (clk),
    .rst_n         (rst_n),
    .rx_data       (bus.rx_data),
    .idle          (idle),
    .fall_edge     (fall_edge),
    .sample_strobe (sample_strobe),
    .sample_bit    (sample_bit),
    .bit_end       (bit_end)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_d;
  end

  // next state plus datapath control strobes
  always_comb begin
    state_d    = state;
    start_c    = 1'b0;
    shift_c    = 1'b0;
    bit_clr_c  = 1'b0;
    bit_inc_c  = 1'b0;
    par_chk_c  = 1'b0;
    stop_chk_c = 1'b0;
    complete_c = 1'b0;
    case (state)
      ST_IDLE: begin
        if (fall_edge) begin
          state_d = ST_START;
          start_c = 1'b1;
        end
      end
      ST_START: begin
        if (sample_strobe && sample_bit) begin
          state_d = ST_IDLE;
        end else if (bit_end) begin
          state_d   = ST_DATA;
          bit_clr_c = 1'b1;
        end
      end
      ST_DATA: begin
        shift_c = sample_strobe;
        if (bit_end) begin
          if (bit_cnt == BIT_W'(DATA_BITS - 1)) begin
            bit_clr_c = 1'b1;
            state_d   = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
          end else begin
            bit_inc_c = 1'b1;
          end
        end
      end
      ST_PARITY: begin
        par_chk_c = sample_strobe;
        if (bit_end) state_d = ST_STOP;
      end
      ST_STOP: begin
        if (sample_strobe) begin
          stop_chk_c = 1'b1;
          // leave at the last stop decision so the next start edge is caught
          if (bit_cnt == BIT_W'(STOP_BITS - 1)) begin
            state_d    = ST_IDLE;
            complete_c = 1'b1;
          end
        end else if (bit_end) begin
          bit_inc_c = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign par_exp = (PARITY == PAR_ODD) ? ~(^shreg) : ^shreg;

  // frame assembly: payload, bit counter, accumulated error flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt <= '0;
      shreg   <= '0;
      flags   <= '0;
    end else if (start_c) begin
      bit_cnt <= '0;
      shreg   <= '0;
      flags   <= '0;
    end else begin
      if (bit_clr_c)      bit_cnt <= '0;
      else if (bit_inc_c) bit_cnt <= bit_cnt + BIT_W'(1);
      if (shift_c)        shreg <= {sample_bit, shreg[DATA_BITS-1:1]};
      if (par_chk_c)      flags.parity_err <= (sample_bit != par_exp);
      if (stop_chk_c && !sample_bit) flags.frame_err <= 1'b1;
    end
  end

  // holding register; a completion against an unaccepted word is dropped
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      po_data_q  <= '0;
      po_valid_q <= 1'b0;
      po_flags_q <= '0;
      overrun_q  <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      overrun_q <= 1'b0;
      busy_q    <= (state_d != ST_IDLE);
      if (complete_c && (!po_valid_q || bus.po_ready)) begin
        po_data_q            <= shreg;
        po_flags_q.frame_err <= flags.frame_err | ~sample_bit;
        po_flags_q.parity_err <= flags.parity_err;
        po_valid_q           <= 1'b1;
      end else if (complete_c) begin
        overrun_q <= 1'b1;
      end else if (po_valid_q && bus.po_ready) begin
        po_valid_q <= 1'b0;
      end
    end
  end

  assign bus.po_data     = po_data_q;
  assign bus.po_valid    = po_valid_q;
  assign bus.frame_err   = po_flags_q.frame_err;
  assign bus.parity_err  = po_flags_q.parity_err;
  assign bus.overrun_err = overrun_q;
  assign bus.busy        = busy_q;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Directed bench for uart_rx_cfg: default 8N1 at BAUD_DIV=434 plus fast
// (BAUD_DIV=16) even-parity, odd-parity and 7-bit/2-stop instances.
module tb_uart_rx_cfg;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  localparam int B0 = 434;
  localparam int M0 = 216;
  localparam int BF = 16;

  logic       rx  [4] = '{1'b1, 1'b1, 1'b1, 1'b1};
  logic       rdy [4] = '{1'b0, 1'b0, 1'b0, 1'b0};
  logic       pv [4], fe [4], pe [4], ov [4], bz [4];
  logic [8:0] pd [4];

  uart_rx_cfg_if #(.DATA_BITS(8)) if_def ();
  uart_rx_cfg_if #(.DATA_BITS(8)) if_even ();
  uart_rx_cfg_if #(.DATA_BITS(8)) if_odd ();
  uart_rx_cfg_if #(.DATA_BITS(7)) if_7s2 ();

  uart_rx_cfg u_def (.clk(clk), .rst_n(rst_n), .bus(if_def));
  uart_rx_cfg #(.CLK_FREQ(1_843_200), .PARITY(2)) u_even (.clk(clk), .rst_n(rst_n), .bus(if_even));
  uart_rx_cfg #(.CLK_FREQ(1_843_200), .PARITY(1)) u_odd (.clk(clk), .rst_n(rst_n), .bus(if_odd));
  uart_rx_cfg #(.CLK_FREQ(1_843_200), .DATA_BITS(7), .STOP_BITS(2)) u_7s2 (.clk(clk), .rst_n(rst_n), .bus(if_7s2));

  assign if_def.rx_data  = rx[0];  assign if_def.po_ready  = rdy[0];
  assign if_even.rx_data = rx[1];  assign if_even.po_ready = rdy[1];
  assign if_odd.rx_data  = rx[2];  assign if_odd.po_ready  = rdy[2];
  assign if_7s2.rx_data  = rx[3];  assign if_7s2.po_ready  = rdy[3];

  assign pv[0] = if_def.po_valid;  assign pd[0] = {1'b0, if_def.po_data};
  assign pv[1] = if_even.po_valid; assign pd[1] = {1'b0, if_even.po_data};
  assign pv[2] = if_odd.po_valid;  assign pd[2] = {1'b0, if_odd.po_data};
  assign pv[3] = if_7s2.po_valid;  assign pd[3] = {2'b0, if_7s2.po_data};
  assign fe[0] = if_def.frame_err;   assign pe[0] = if_def.parity_err;
  assign fe[1] = if_even.frame_err;  assign pe[1] = if_even.parity_err;
  assign fe[2] = if_odd.frame_err;   assign pe[2] = if_odd.parity_err;
  assign fe[3] = if_7s2.frame_err;   assign pe[3] = if_7s2.parity_err;
  assign ov[0] = if_def.overrun_err; assign bz[0] = if_def.busy;
  assign ov[1] = if_even.overrun_err; assign bz[1] = if_even.busy;
  assign ov[2] = if_odd.overrun_err;  assign bz[2] = if_odd.busy;
  assign ov[3] = if_7s2.overrun_err;  assign bz[3] = if_7s2.busy;

  // transfer log per instance, sampled on the falling edge
  int         n_xfer [4] = '{default: 0};
  int         n_ovr  [4] = '{default: 0};
  int         n_vhi  [4] = '{default: 0};
  int         rise_cyc [4] = '{default: 0};
  int         start_cyc [4] = '{default: 0};
  logic [8:0] x_data [4];
  logic       x_fe [4], x_pe [4];
  logic       pv_q [4] = '{default: 1'b0};

  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (pv[i]) n_vhi[i]++;
      if (pv[i] && !pv_q[i]) rise_cyc[i] = cyc;
      if (pv[i] && rdy[i]) begin
        n_xfer[i]++;
        x_data[i] = pd[i];
        x_fe[i]   = fe[i];
        x_pe[i]   = pe[i];
      end
      if (ov[i]) n_ovr[i]++;
      pv_q[i] = pv[i];
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] frame_bits(input logic [8:0] d, input int db,
                                             input int usep, input logic pbit,
                                             input int ns, input logic s1, input logic s2);
    logic [15:0] b;
    int k;
    b = '1;
    b[0] = 1'b0;
    k = 1;
    for (int i = 0; i < db; i++) begin b[k] = d[i]; k++; end
    if (usep != 0) begin b[k] = pbit; k++; end
    b[k] = s1;
    k++;
    if (ns == 2) b[k] = s2;
    return b;
  endfunction

  task automatic send_frame(input int ch, input logic [15:0] bits, input int nbits, input int bdiv);
    start_cyc[ch] = cyc;
    for (int i = 0; i < nbits; i++) begin
      rx[ch] = bits[i];
      tick(bdiv);
    end
    rx[ch] = 1'b1;
  endtask

  task automatic test_reset;
    tick(5);
    checks++; if (if_def.po_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", if_def.po_valid); end
    checks++; if (if_def.po_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h want 00", if_def.po_data); end
    checks++; if ({if_def.frame_err, if_def.parity_err, if_def.overrun_err} !== 3'b000) begin
      errors++; $display("FAIL reset_flags: got %b want 000", {if_def.frame_err, if_def.parity_err, if_def.overrun_err}); end
    checks++; if (if_def.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", if_def.busy); end
    rst_n = 1'b1;
    tick(5);
    checks++; if (if_def.po_valid !== 1'b0 || if_def.busy !== 1'b0) begin
      errors++; $display("FAIL post_reset_idle: valid %b busy %b want 0 0", if_def.po_valid, if_def.busy); end
  endtask

  task automatic test_basic;
    int x0, v0;
    rdy[0] = 1'b1;
    x0 = n_xfer[0]; v0 = n_vhi[0];
    send_frame(0, frame_bits(9'h0A5, 8, 0, 1'b0, 1, 1'b1, 1'b1), 10, B0);
    tick(20);
    checks++; if (n_xfer[0] - x0 !== 1) begin errors++; $display("FAIL basic_count: got %0d transfers want 1", n_xfer[0] - x0); end
    checks++; if (x_data[0] !== 9'h0A5) begin errors++; $display("FAIL basic_data: got %h want 0a5", x_data[0]); end
    checks++; if ({x_fe[0], x_pe[0]} !== 2'b00) begin errors++; $display("FAIL basic_flags: got %b want 00", {x_fe[0], x_pe[0]}); end
    checks++; if (n_vhi[0] - v0 !== 1) begin errors++; $display("FAIL basic_pulse: valid high %0d cycles want 1", n_vhi[0] - v0); end
    // counted from the first clock edge that samples the low line: 2 + 9*434 + 216 + 2
    checks++; if (rise_cyc[0] - start_cyc[0] - 1 !== 2 + 9 * B0 + M0 + 2) begin
      errors++; $display("FAIL basic_latency: got %0d want %0d", rise_cyc[0] - start_cyc[0] - 1, 2 + 9 * B0 + M0 + 2); end
  endtask

  task automatic test_parity;
    rdy[1] = 1'b1; rdy[2] = 1'b1;
    send_frame(1, frame_bits(9'h03C, 8, 1, 1'b0, 1, 1'b1, 1'b1), 11, BF);
    tick(20);
    checks++; if ({x_data[1], x_fe[1], x_pe[1]} !== {9'h03C, 2'b00}) begin
      errors++; $display("FAIL even_ok: got data %h fe %b pe %b want 03c 0 0", x_data[1], x_fe[1], x_pe[1]); end
    send_frame(1, frame_bits(9'h03C, 8, 1, 1'b1, 1, 1'b1, 1'b1), 11, BF);
    tick(20);
    checks++; if ({x_data[1], x_fe[1], x_pe[1]} !== {9'h03C, 2'b01}) begin
      errors++; $display("FAIL even_bad: got data %h fe %b pe %b want 03c 0 1", x_data[1], x_fe[1], x_pe[1]); end
    checks++; if (n_xfer[1] !== 2) begin errors++; $display("FAIL even_count: got %0d want 2", n_xfer[1]); end
    send_frame(2, frame_bits(9'h03C, 8, 1, 1'b1, 1, 1'b1, 1'b1), 11, BF);
    tick(20);
    checks++; if ({x_data[2], x_fe[2], x_pe[2]} !== {9'h03C, 2'b00}) begin
      errors++; $display("FAIL odd_ok: got data %h fe %b pe %b want 03c 0 0", x_data[2], x_fe[2], x_pe[2]); end
    send_frame(2, frame_bits(9'h03C, 8, 1, 1'b0, 1, 1'b1, 1'b1), 11, BF);
    tick(20);
    checks++; if (x_pe[2] !== 1'b1) begin errors++; $display("FAIL odd_bad: got pe %b want 1", x_pe[2]); end
  endtask

  task automatic test_frame_err;
    send_frame(0, frame_bits(9'h055, 8, 0, 1'b0, 1, 1'b0, 1'b1), 10, B0);
    tick(20);
    checks++; if ({x_data[0], x_fe[0], x_pe[0]} !== {9'h055, 2'b10}) begin
      errors++; $display("FAIL frame_8n1: got data %h fe %b pe %b want 055 1 0", x_data[0], x_fe[0], x_pe[0]); end
    rdy[3] = 1'b1;
    send_frame(3, frame_bits(9'h02A, 7, 0, 1'b0, 2, 1'b1, 1'b1), 10, BF);
    tick(20);
    checks++; if ({x_data[3], x_fe[3]} !== {9'h02A, 1'b0}) begin
      errors++; $display("FAIL frame_7s2_ok: got data %h fe %b want 02a 0", x_data[3], x_fe[3]); end
    send_frame(3, frame_bits(9'h02A, 7, 0, 1'b0, 2, 1'b1, 1'b0), 10, BF);
    tick(20);
    checks++; if ({x_data[3], x_fe[3]} !== {9'h02A, 1'b1}) begin
      errors++; $display("FAIL frame_7s2_stop2: got data %h fe %b want 02a 1", x_data[3], x_fe[3]); end
  endtask

  task automatic test_false_start;
    int x0;
    x0 = n_xfer[0];
    rx[0] = 1'b0;
    tick(100);
    rx[0] = 1'b1;
    tick(M0 + 3 - 100);
    checks++; if (if_def.busy !== 1'b1) begin errors++; $display("FAIL false_busy_hi: got %b want 1", if_def.busy); end
    tick(3);
    checks++; if (if_def.busy !== 1'b0) begin errors++; $display("FAIL false_busy_lo: got %b want 0", if_def.busy); end
    tick(11 * B0);
    checks++; if (n_xfer[0] !== x0 || if_def.po_valid !== 1'b0) begin
      errors++; $display("FAIL false_output: got %0d transfers valid %b want 0 0", n_xfer[0] - x0, if_def.po_valid); end
  endtask

  task automatic test_glitch;
    fork
      send_frame(0, frame_bits(9'h000, 8, 0, 1'b0, 1, 1'b1, 1'b1), 10, B0);
      begin
        // one-cycle high seen by the sampler at cnt == MID of data bit 3
        tick(1 + 4 * B0 + M0);
        rx[0] = 1'b1;
        tick(1);
        rx[0] = 1'b0;
      end
    join
    tick(20);
    checks++; if ({x_data[0], x_fe[0]} !== {9'h000, 1'b0}) begin
      errors++; $display("FAIL glitch_vote: got data %h fe %b want 000 0", x_data[0], x_fe[0]); end
  endtask

  task automatic test_back_to_back;
    int x0, o0;
    rdy[0] = 1'b0;
    x0 = n_xfer[0]; o0 = n_ovr[0];
    send_frame(0, frame_bits(9'h011, 8, 0, 1'b0, 1, 1'b1, 1'b1), 10, B0);
    send_frame(0, frame_bits(9'h022, 8, 0, 1'b0, 1, 1'b1, 1'b1), 10, B0);
    tick(20);
    checks++; if (n_ovr[0] - o0 !== 1) begin errors++; $display("FAIL b2b_overrun: got %0d pulse cycles want 1", n_ovr[0] - o0); end
    checks++; if (if_def.po_valid !== 1'b1 || if_def.po_data !== 8'h11) begin
      errors++; $display("FAIL b2b_hold: got valid %b data %h want 1 11", if_def.po_valid, if_def.po_data); end
    checks++; if (n_xfer[0] !== x0) begin errors++; $display("FAIL b2b_no_xfer: got %0d want 0", n_xfer[0] - x0); end
    rdy[0] = 1'b1;
    tick(3);
    checks++; if (n_xfer[0] - x0 !== 1 || x_data[0] !== 9'h011) begin
      errors++; $display("FAIL b2b_drain: got %0d transfers data %h want 1 011", n_xfer[0] - x0, x_data[0]); end
    checks++; if (if_def.po_valid !== 1'b0) begin errors++; $display("FAIL b2b_empty: got valid %b want 0", if_def.po_valid); end
  endtask

  task automatic test_reset_midframe;
    int x0;
    fork
      send_frame(0, frame_bits(9'h0F0, 8, 0, 1'b0, 1, 1'b1, 1'b1), 10, B0);
      begin
        tick(5 * B0 + 100);
        rst_n = 1'b0;
        tick(3);
        rst_n = 1'b1;
        tick(1);
        checks++; if (if_def.busy !== 1'b0 || if_def.po_valid !== 1'b0) begin
          errors++; $display("FAIL midrst_clear: busy %b valid %b want 0 0", if_def.busy, if_def.po_valid); end
      end
    join
    tick(20);
    x0 = n_xfer[0];
    send_frame(0, frame_bits(9'h00F, 8, 0, 1'b0, 1, 1'b1, 1'b1), 10, B0);
    tick(20);
    checks++; if (n_xfer[0] - x0 !== 1) begin errors++; $display("FAIL midrst_count: got %0d want 1", n_xfer[0] - x0); end
    checks++; if ({x_data[0], x_fe[0], x_pe[0]} !== {9'h00F, 2'b00}) begin
      errors++; $display("FAIL midrst_data: got data %h fe %b pe %b want 00f 0 0", x_data[0], x_fe[0], x_pe[0]); end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_parity;
    test_frame_err;
    test_false_start;
    test_glitch;
    test_back_to_back;
    test_reset_midframe;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
